// File: rtl/mcdecode.sv
// Multicycle main decoder for an ARM-like datapath.
// Sequences fetch/decode/execute and an optional iterative multiplier.
module mcdecode #(
  parameter int ALUCTL_W    = 3,
  parameter int MUL_EN      = 1,
  parameter int MUL_TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          Op,
  input  logic [5:0]          Funct,
  input  logic [3:0]          Rd,
  input  logic [3:0]          InstrLo,
  input  logic                MulDone,
  output logic                PCS,
  output logic                NextPC,
  output logic                RegW,
  output logic                MemW,
  output logic                IRWrite,
  output logic                AdrSrc,
  output logic                MulStart,
  output logic                Undef,
  output logic [1:0]          FlagW,
  output logic [1:0]          ResultSrc,
  output logic [1:0]          ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [1:0]          ImmSrc,
  output logic [1:0]          RegSrc,
  output logic [ALUCTL_W-1:0] ALUControl,
  output logic [3:0]          State
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_MULWAIT  = 4'd10;
  localparam logic [3:0] S_MULWB    = 4'd11;

  localparam int CNT_W = $clog2(MUL_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MUL_TIMEOUT);

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             inhib_q, inhib_d;

  logic       is_mul;
  logic       alu_ok;
  logic       is_cmp;
  logic       is_arith;
  logic [2:0] alu3;
  logic       alu_act;
  logic       branch;
  logic       mul_tmo;
  logic       undef_raw;
  logic       mstart_raw;
  logic       regw_raw;

  assign is_mul = (MUL_EN != 0) &&
                  (Op == 2'b00) &&
                  (Funct[5:4] == 2'b00) &&
                  (InstrLo == 4'b1001);

  // ALU operation decode from the command field
  always_comb begin
    alu3     = 3'b000;
    alu_ok   = 1'b1;
    is_cmp   = 1'b0;
    is_arith = 1'b0;
    case (Funct[4:1])
      4'b0100: begin
        alu3     = 3'b000;
        is_arith = 1'b1;
      end
      4'b0010: begin
        alu3     = 3'b001;
        is_arith = 1'b1;
      end
      4'b0000: alu3 = 3'b010;
      4'b1100: alu3 = 3'b011;
      4'b0001: alu3 = 3'b100;
      4'b1101: alu3 = 3'b101;
      4'b1010: begin
        alu3     = 3'b001;
        is_arith = 1'b1;
        is_cmp   = 1'b1;
      end
      default: alu_ok = 1'b0;
    endcase
  end

  assign mul_tmo = (cnt_q == CNT_MAX) && !MulDone;

  // Next-state, counter and writeback-inhibit update
  always_comb begin
    state_d = S_FETCH;
    cnt_d   = '0;
    inhib_d = inhib_q;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          (Op == 2'b11): state_d = S_FETCH;
          (Op == 2'b01): state_d = S_MEMADR;
          (Op == 2'b10): state_d = S_BRANCH;
          is_mul:        state_d = S_MULWAIT;
          (Op == 2'b00 && Funct[5]):
                         state_d = S_EXECI;
          default:       state_d = S_EXECR;
        endcase
      end
      S_MEMADR:
        state_d = Funct[0] ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = S_FETCH;
      S_EXECR, S_EXECI: begin
        state_d = S_ALUWB;
        inhib_d = is_cmp || !alu_ok;
      end
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_MULWAIT: begin
        if (MulDone)
          state_d = S_MULWB;
        else if (mul_tmo)
          state_d = S_FETCH;
        else
          state_d = S_MULWAIT;
        if (cnt_q == CNT_MAX)
          cnt_d = cnt_q;
        else
          cnt_d = cnt_q + CNT_W'(1);
      end
      S_MULWB:  state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // State registers with asynchronous abort on reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      inhib_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      inhib_q <= inhib_d;
    end
  end

  // Per-state control outputs; everything idles at zero
  always_comb begin
    NextPC     = 1'b0;
    regw_raw   = 1'b0;
    MemW       = 1'b0;
    IRWrite    = 1'b0;
    AdrSrc     = 1'b0;
    mstart_raw = 1'b0;
    undef_raw  = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    branch     = 1'b0;
    alu_act    = 1'b0;
    case (state_q)
      S_FETCH: begin
        IRWrite   = 1'b1;
        NextPC    = 1'b1;
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_DECODE: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        undef_raw = (Op == 2'b11);
      end
      S_MEMADR:  ALUSrcB = 2'b01;
      S_MEMREAD: AdrSrc  = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        regw_raw  = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc = 1'b1;
        MemW   = 1'b1;
      end
      S_EXECR: begin
        alu_act   = 1'b1;
        undef_raw = !alu_ok;
      end
      S_EXECI: begin
        ALUSrcB   = 2'b01;
        alu_act   = 1'b1;
        undef_raw = !alu_ok;
      end
      S_ALUWB:  regw_raw = !inhib_q;
      S_BRANCH: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        branch    = 1'b1;
      end
      S_MULWAIT: begin
        mstart_raw = (cnt_q == '0);
        undef_raw  = mul_tmo;
      end
      S_MULWB: begin
        ResultSrc = 2'b11;
        regw_raw  = 1'b1;
      end
      default: ;
    endcase
  end

  // ALU control and flag enables, only while an ALU op executes
  always_comb begin
    ALUControl = '0;
    FlagW      = 2'b00;
    if (alu_act) begin
      ALUControl = ALUCTL_W'(alu3);
      FlagW[1]   = Funct[0];
      FlagW[0]   = Funct[0] && is_arith;
    end
  end

  assign RegW     = regw_raw && reset;
  assign MulStart = mstart_raw && reset;
  assign Undef    = undef_raw && reset;
  assign PCS      = ((Rd == 4'b1111) && RegW) || branch;
  assign ImmSrc   = Op;
  assign RegSrc   = {(Op == 2'b01), (Op == 2'b10)};
  assign State    = state_q;

endmodule
